// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg : FP32 field layout, compare/select op encoding and special values
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fpu_pkg;

   localparam int SIGN_BIT = 31;
   localparam int EXP_W    = 8;
   localparam int MAN_W    = 23;
   localparam int EXP_LSB  = MAN_W;
   localparam int QNAN_BIT = MAN_W - 1;

   localparam logic [2:0] OP_FEQ  = 3'd0;
   localparam logic [2:0] OP_FLT  = 3'd1;
   localparam logic [2:0] OP_FLE  = 3'd2;
   localparam logic [2:0] OP_FMIN = 3'd3;
   localparam logic [2:0] OP_FMAX = 3'd4;

   localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
   localparam logic [31:0] POS_ZERO  = 32'h0000_0000;
   localparam logic [31:0] NEG_ZERO  = 32'h8000_0000;

   typedef struct packed {
      logic             sign;
      logic [EXP_W-1:0] exp;
      logic [MAN_W-1:0] man;
   } fp32_t;

   function automatic logic is_nan(input fp32_t x);
      return (&x.exp) && (|x.man);
   endfunction

endpackage : fpu_pkg

`default_nettype wire

// File: rtl/fcmp_core.sv
// ---------------------------------------------------------------------------
// fcmp_core : combinational FP32 ordering (lt/eq) with optional NaN flags.
// Optional feature macro: FCMP_NAN_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fcmp_core
   import fpu_pkg::*;
(
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic        o_lt,
   output logic        o_eq
`ifdef FCMP_NAN_EN
   ,
   output logic        o_a_nan,
   output logic        o_b_nan,
   output logic        o_snan
`endif
);

   fp32_t                 w_a;
   fp32_t                 w_b;
   logic [EXP_W+MAN_W-1:0] w_mag_a;
   logic [EXP_W+MAN_W-1:0] w_mag_b;
   logic                  w_zero_pair;
   logic                  w_order;

   assign w_a     = i_a;
   assign w_b     = i_b;
   assign w_mag_a = {w_a.exp, w_a.man};
   assign w_mag_b = {w_b.exp, w_b.man};

   // -0 and +0 compare equal regardless of operand order
   assign w_zero_pair = ((i_a == NEG_ZERO) && (i_b == POS_ZERO)) ||
                        ((i_a == POS_ZERO) && (i_b == NEG_ZERO));

   assign o_eq = (i_a == i_b) || w_zero_pair;

   always_comb begin
      w_order = 1'b0;
      case ({i_a[SIGN_BIT], i_b[SIGN_BIT]})
         2'b10:   w_order = 1'b1;
         2'b00:   w_order = (w_mag_a < w_mag_b);
         2'b11:   w_order = (w_mag_a > w_mag_b);
         default: w_order = 1'b0;
      endcase
   end

   assign o_lt = ~o_eq & w_order;

`ifdef FCMP_NAN_EN
   assign o_a_nan = is_nan(w_a);
   assign o_b_nan = is_nan(w_b);
   assign o_snan  = (o_a_nan & ~w_a.man[QNAN_BIT]) | (o_b_nan & ~w_b.man[QNAN_BIT]);
`endif

endmodule : fcmp_core

`default_nettype wire

// File: rtl/fcmp_pipe.sv
// ---------------------------------------------------------------------------
// fcmp_pipe : 2-stage valid/ready FP32 compare/select (FEQ/FLT/FLE/FMIN/FMAX).
// Optional feature macro: FCMP_NAN_EN (NaN-aware results, out_nv).  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fcmp_pipe
   import fpu_pkg::*;
#(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic [2:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_res,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_ill
`ifdef FCMP_NAN_EN
   ,
   output logic             out_nv
`endif
);

   logic             r_s1_valid;
   logic [31:0]      r_s1_a;
   logic [31:0]      r_s1_b;
   logic [2:0]       r_s1_op;
   logic [TAG_W-1:0] r_s1_tag;

   logic             r_s2_valid;
   logic [31:0]      r_s2_res;
   logic [TAG_W-1:0] r_s2_tag;
   logic             r_s2_ill;

   logic             w_s1_ready;
   logic             w_s2_ready;
   logic             w_lt;
   logic             w_eq;
   logic [31:0]      w_res;
   logic             w_ill;

`ifdef FCMP_NAN_EN
   logic             w_a_nan;
   logic             w_b_nan;
   logic             w_snan;
   logic             w_nv;
   logic             r_s2_nv;
`endif

   assign w_s2_ready = ~r_s2_valid | out_ready;
   assign w_s1_ready = ~r_s1_valid | w_s2_ready;
   assign in_ready   = w_s1_ready;

   fcmp_core u_core (
      .i_a     (r_s1_a),
      .i_b     (r_s1_b),
      .o_lt    (w_lt),
      .o_eq    (w_eq)
`ifdef FCMP_NAN_EN
      ,
      .o_a_nan (w_a_nan),
      .o_b_nan (w_b_nan),
      .o_snan  (w_snan)
`endif
   );

   // Result select; FMIN/FMAX both fall back to b when the operands compare equal
   always_comb begin
      w_res = 32'h0;
      w_ill = 1'b0;
      case (r_s1_op)
         OP_FEQ:  w_res = {31'b0, w_eq};
         OP_FLT:  w_res = {31'b0, w_lt};
         OP_FLE:  w_res = {31'b0, w_lt | w_eq};
         OP_FMIN: w_res = w_lt ? r_s1_a : r_s1_b;
         OP_FMAX: w_res = (w_lt | w_eq) ? r_s1_b : r_s1_a;
         default: w_ill = 1'b1;
      endcase
`ifdef FCMP_NAN_EN
      w_nv = 1'b0;
      if (!w_ill) begin
         if (w_a_nan || w_b_nan) begin
            if (r_s1_op == OP_FMIN || r_s1_op == OP_FMAX) begin
               if (w_a_nan && w_b_nan) begin
                  w_res = CANON_NAN;
               end else if (w_a_nan) begin
                  w_res = r_s1_b;
               end else begin
                  w_res = r_s1_a;
               end
            end else begin
               w_res = 32'h0;
            end
         end
         w_nv = (((r_s1_op == OP_FLT) || (r_s1_op == OP_FLE)) && (w_a_nan || w_b_nan)) || w_snan;
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= 32'h0;
         r_s1_b     <= 32'h0;
         r_s1_op    <= 3'd0;
         r_s1_tag   <= '0;
      end else if (w_s1_ready) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_a   <= in_a;
            r_s1_b   <= in_b;
            r_s1_op  <= in_op;
            r_s1_tag <= in_tag;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_res   <= 32'h0;
         r_s2_tag   <= '0;
         r_s2_ill   <= 1'b0;
`ifdef FCMP_NAN_EN
         r_s2_nv    <= 1'b0;
`endif
      end else if (w_s2_ready) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_res <= w_res;
            r_s2_tag <= r_s1_tag;
            r_s2_ill <= w_ill;
`ifdef FCMP_NAN_EN
            r_s2_nv  <= w_nv;
`endif
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign out_res   = r_s2_res;
   assign out_tag   = r_s2_tag;
   assign out_ill   = r_s2_ill;
`ifdef FCMP_NAN_EN
   assign out_nv    = r_s2_nv;
`endif

endmodule : fcmp_pipe

`default_nettype wire
